// File: rtl/poly_voice_engine_pkg.sv
// Shared definitions for the polyphonic voice engine: waveform codes, FSM states
// and a constant-width helper.
package synth_pkg;

  localparam logic [1:0] WAVE_SAW = 2'b00;
  localparam logic [1:0] WAVE_SQR = 2'b01;
  localparam logic [1:0] WAVE_TRI = 2'b10;
  localparam logic [1:0] WAVE_PUL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SWEEP,
    DONE,
    ALLOC,
    COMMIT
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/poly_voice_engine_if.sv
// Note-event handshake, frequency-lookup side channel and mixed-sample output of the engine.
// slave = engine side, master = note source / DAC side.
interface poly_voice_engine_if
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16
);
  localparam int MIX_W = OUT_W + clog2(NUM_VOICES);

  logic                    note_valid;
  logic                    note_ready;
  logic                    note_on;
  logic [6:0]              note_num;
  logic [1:0]              ctrl;
  logic [6:0]              lut_note;
  logic [PHASE_W-1:0]      lut_inc;
  logic [NUM_VOICES-1:0]   voice_active;
  logic signed [MIX_W-1:0] mix_out;
  logic                    mix_valid;

  modport slave (
    input  note_valid, note_on, note_num, ctrl, lut_inc,
    output note_ready, lut_note, voice_active, mix_out, mix_valid
  );

  modport master (
    output note_valid, note_on, note_num, ctrl, lut_inc,
    input  note_ready, lut_note, voice_active, mix_out, mix_valid
  );

endinterface

// File: rtl/poly_voice_engine_wave.sv
// Combinational waveform shaper: top OUT_W phase bits plus mode -> signed sample.
// Zero latency; shared by every voice slot of the sweep.
module poly_wave_shaper
  import synth_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0]        phase,
  input  logic [1:0]              ctrl,
  output logic signed [OUT_W-1:0] sample
);
  localparam logic signed [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Second half of the cycle mirrors the first so the triangle descends.
  logic [OUT_W-2:0] fold;
  assign fold = phase[OUT_W-1] ? ~phase[OUT_W-2:0] : phase[OUT_W-2:0];

  always_comb begin
    sample = '0;
    case (ctrl)
      WAVE_SAW: sample = {~phase[OUT_W-1], phase[OUT_W-2:0]};
      WAVE_SQR: sample = phase[OUT_W-1] ? S_MIN : S_MAX;
      WAVE_TRI: sample = {~fold[OUT_W-2], fold[OUT_W-3:0], 1'b0};
      WAVE_PUL: sample = (phase[OUT_W-1:OUT_W-2] == 2'b00) ? S_MAX : S_MIN;
      default:  sample = '0;
    endcase
  end

endmodule

// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic oscillator with voice allocation; mix_valid N+1 cycles after a sweep
// starts. note_ready only in IDLE with no sample tick pending; ticks during allocation are deferred.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16,
  parameter int SAMPLE_DIV = 1024,
  parameter int AGE_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  poly_voice_engine_if.slave bus
);
  localparam int VW    = clog2(NUM_VOICES);
  localparam int MIX_W = OUT_W + VW;
  localparam int CNT_W = clog2(SAMPLE_DIV);
  localparam logic [VW-1:0] V_LAST = VW'(NUM_VOICES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    tick_pending;
  logic [VW-1:0]           v;
  logic signed [MIX_W-1:0] acc;
  logic [NUM_VOICES-1:0]   active;
  logic [PHASE_W-1:0]      phase_r [NUM_VOICES];
  logic [6:0]              note_r  [NUM_VOICES];
  logic [AGE_W-1:0]        age_r   [NUM_VOICES];

  logic                    ev_on;
  logic [6:0]              ev_note;
  logic                    match_vld, free_vld, old_vld;
  logic [VW-1:0]           match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]        old_age;

  logic signed [MIX_W-1:0] mix_out_r;
  logic                    mix_valid_r;

  logic                    wrap;
  logic signed [OUT_W-1:0] sample;
  logic signed [MIX_W-1:0] acc_next;
  logic [VW-1:0]           target;

  poly_wave_shaper #(.OUT_W(OUT_W)) u_shaper (
    .phase  (phase_r[v][PHASE_W-1 -: OUT_W]),
    .ctrl   (bus.ctrl),
    .sample (sample)
  );

  assign wrap     = (cnt == CNT_W'(SAMPLE_DIV - 1));
  assign acc_next = acc + (active[v] ? {{VW{sample[OUT_W-1]}}, sample} : '0);
  // Retrigger beats a free slot, a free slot beats stealing the oldest voice.
  assign target   = match_vld ? match_idx : (free_vld ? free_idx : old_idx);

  assign bus.note_ready   = reset && (state == IDLE) && !tick_pending;
  assign bus.lut_note     = note_r[v];
  assign bus.voice_active = active;
  assign bus.mix_out      = mix_out_r;
  assign bus.mix_valid    = mix_valid_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      tick_pending <= 1'b0;
      v            <= '0;
      acc          <= '0;
      active       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_r[i] <= '0;
        note_r[i]  <= '0;
        age_r[i]   <= '0;
      end
      ev_on       <= 1'b0;
      ev_note     <= '0;
      match_vld   <= 1'b0;
      free_vld    <= 1'b0;
      old_vld     <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      mix_out_r   <= '0;
      mix_valid_r <= 1'b0;
    end else begin
      cnt         <= wrap ? '0 : cnt + CNT_W'(1);
      mix_valid_r <= 1'b0;
      if (wrap)
        tick_pending <= 1'b1;
      else if (state == IDLE && tick_pending)
        tick_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (tick_pending) begin
            state <= SWEEP;
            acc   <= '0;
            v     <= '0;
          end else if (bus.note_valid) begin
            ev_on     <= bus.note_on;
            ev_note   <= bus.note_num;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            old_vld   <= 1'b0;
            v         <= '0;
            state     <= ALLOC;
          end
        end
        SWEEP: begin
          acc <= acc_next;
          if (active[v])
            phase_r[v] <= phase_r[v] + bus.lut_inc;
          if (v == V_LAST) begin
            mix_out_r   <= acc_next;
            mix_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            v <= v + VW'(1);
          end
        end
        DONE: state <= IDLE;
        ALLOC: begin
          if (active[v] && note_r[v] == ev_note && !match_vld) begin
            match_vld <= 1'b1;
            match_idx <= v;
          end
          if (!active[v] && !free_vld) begin
            free_vld <= 1'b1;
            free_idx <= v;
          end
          // Strictly-greater keeps the lowest index on equal ages.
          if (active[v] && (!old_vld || age_r[v] > old_age)) begin
            old_vld <= 1'b1;
            old_idx <= v;
            old_age <= age_r[v];
          end
          if (v == V_LAST) state <= COMMIT;
          else             v     <= v + VW'(1);
        end
        COMMIT: begin
          if (ev_on) begin
            for (int i = 0; i < NUM_VOICES; i++)
              if (active[i] && VW'(i) != target && age_r[i] != '1)
                age_r[i] <= age_r[i] + AGE_W'(1);
            active[target]  <= 1'b1;
            note_r[target]  <= ev_note;
            phase_r[target] <= '0;
            age_r[target]   <= '0;
          end else if (match_vld) begin
            active[match_idx] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed and randomised note traffic against a voice-list reference model of the engine.
`timescale 1ns/1ps
module tb_poly_voice_engine;
  import synth_pkg::*;

  localparam int NV = 16, PW = 24, OW = 16, SD = 64, AW = 8;
  localparam int HALF  = 1 << (OW - 1);
  localparam int FULLS = 1 << OW;
  localparam longint PMOD = 64'd1 << PW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  poly_voice_engine_if #(.NUM_VOICES(NV), .PHASE_W(PW), .OUT_W(OW)) ifc ();

  poly_voice_engine #(
    .NUM_VOICES(NV), .PHASE_W(PW), .OUT_W(OW), .SAMPLE_DIV(SD), .AGE_W(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  logic [PW-1:0] inc_tab [128];
  assign ifc.lut_inc = inc_tab[ifc.lut_note];

  // Reference model: a plain list of voices.
  bit     m_act  [NV];
  int     m_note [NV];
  longint m_ph   [NV];
  int     m_age  [NV];

  int total = 0, bad = 0;
  int cyc = 0, wraps = 0, pulses = 0, last_wrap = 0, mix_lat = 0, last_mix = 0;
  bit got_mix = 0, rand_ctrl = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int wave(input longint ph, input int c);
    int u;
    u = int'(ph >> (PW - OW));
    case (c)
      0:       return u - HALF;
      1:       return (u >= HALF) ? -HALF : HALF - 1;
      2:       return ((u < HALF) ? 2 * u : 2 * (FULLS - 1 - u)) - HALF;
      default: return (u < HALF / 2) ? HALF - 1 : -HALF;
    endcase
  endfunction

  task automatic model_sweep(input int c, output int s);
    s = 0;
    for (int i = 0; i < NV; i++)
      if (m_act[i]) begin
        s += wave(m_ph[i], c);
        m_ph[i] = (m_ph[i] + longint'(inc_tab[m_note[i]])) % PMOD;
      end
  endtask

  task automatic model_note(input bit on, input int n);
    int tgt;
    tgt = -1;
    for (int i = 0; i < NV; i++)
      if (m_act[i] && m_note[i] == n) tgt = i;
    if (!on) begin
      if (tgt >= 0) m_act[tgt] = 0;
      return;
    end
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && !m_act[i]) tgt = i;
    if (tgt < 0) begin
      tgt = 0;
      for (int i = 1; i < NV; i++)
        if (m_age[i] > m_age[tgt]) tgt = i;
    end
    for (int i = 0; i < NV; i++)
      if (m_act[i] && i != tgt && m_age[i] < (1 << AW) - 1) m_age[i]++;
    m_act[tgt] = 1; m_note[tgt] = n; m_ph[tgt] = 0; m_age[tgt] = 0;
  endtask

  function automatic longint m_active_vec();
    longint r;
    r = 0;
    for (int i = 0; i < NV; i++)
      if (m_act[i]) r |= (longint'(1) << i);
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_ph[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic step();
    int got, exp;
    @(posedge clk); #1;
    cyc++;
    if (cyc % SD == 0) begin
      wraps++;
      last_wrap = cyc;
    end
    if (ifc.mix_valid) begin
      got = ifc.mix_out;
      model_sweep(int'(ifc.ctrl), exp);
      pulses++;
      mix_lat  = cyc - last_wrap;
      last_mix = got;
      got_mix  = 1;
      check("mix_out", got, exp);
      check("pulse_per_wrap", pulses, wraps);
      check("mix_latency_window", (mix_lat >= NV + 1 && mix_lat <= 2 * NV + 3), 1);
      if (rand_ctrl) ifc.ctrl = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_mix();
    got_mix = 0;
    for (int k = 0; k < 2 * SD + 40 && !got_mix; k++) step();
    check("mix_seen", got_mix, 1);
  endtask

  task automatic send_note(input bit on, input int n, output int rc);
    bit done;
    done = 0;
    rc = -1;
    ifc.note_on = on;
    ifc.note_num = 7'(n);
    ifc.note_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (ifc.note_ready) begin
        model_note(on, n);
        rc = cyc;
        done = 1;
      end
      step();
    end
    ifc.note_valid = 1'b0;
    check("note_accepted", done, 1);
    repeat (17) step();
    check("voice_active", ifc.voice_active, m_active_vec());
  endtask

  initial begin
    int c0, rc, n;
    bit on, seen;
    ifc.note_valid = 1'b0;
    ifc.note_on = 1'b0;
    ifc.note_num = '0;
    ifc.ctrl = WAVE_SAW;
    for (int i = 0; i < 128; i++) inc_tab[i] = '0;
    model_clear();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_note_ready", ifc.note_ready, 0);
    check("rst_mix_valid", ifc.mix_valid, 0);
    check("rst_mix_out", ifc.mix_out, 0);
    check("rst_voice_active", ifc.voice_active, 0);
    check("rst_lut_note", ifc.lut_note, 0);
    reset = 1'b1;
    cyc = 0;

    // Silent engine: sample cadence and latency
    wait_mix();
    check("idle_latency", mix_lat, NV + 1);
    check("idle_mix", last_mix, 0);
    check("idle_active", ifc.voice_active, 0);
    c0 = cyc;
    wait_mix();
    check("sample_period", cyc - c0, SD);

    // Single saw voice
    inc_tab[60] = 24'h100000;
    send_note(1, 60, rc);
    check("one_voice", ifc.voice_active, 1);
    wait_mix();
    check("saw_step0", last_mix, -32768);
    wait_mix();
    check("saw_step1", last_mix, -28672);

    // Retrigger and note-off
    send_note(1, 60, rc);
    check("retrig_single", ifc.voice_active, 1);
    wait_mix();
    check("retrig_phase0", last_mix, -32768);
    send_note(0, 61, rc);
    check("off_unknown", ifc.voice_active, 1);
    send_note(0, 60, rc);
    check("off_clears", ifc.voice_active, 0);

    // Fill all voices and steal the oldest
    rand_ctrl = 1;
    for (int k = 40; k <= 56; k++) begin
      inc_tab[k] = PW'($urandom);
      send_note(1, k, rc);
    end
    check("steal_full", ifc.voice_active, 16'hFFFF);
    send_note(0, 40, rc);
    check("stolen_note_gone", ifc.voice_active, 16'hFFFF);
    send_note(0, 56, rc);
    check("steal_voice0", ifc.voice_active, 16'hFFFE);
    wait_mix();
    for (int k = 41; k <= 55; k++) send_note(0, k, rc);
    check("steal_cleared", ifc.voice_active, 0);

    // Note offered exactly when the counter wraps
    inc_tab[33] = PW'($urandom);
    repeat (40) step();
    do step(); while (cyc % SD != 0);
    check("ready_at_wrap", ifc.note_ready, 0);
    c0 = cyc;
    send_note(1, 33, rc);
    check("accept_after_done", rc - c0, NV + 2);

    // Random note traffic
    for (int k = 30; k <= 50; k++) inc_tab[k] = PW'($urandom);
    for (int k = 0; k < 40; k++) begin
      n = int'($urandom_range(30, 50));
      on = ($urandom_range(0, 2) != 0);
      send_note(on, n, rc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, SD)) step();
    end
    wait_mix();

    // Full-scale square sum
    rand_ctrl = 0;
    for (int i = 0; i < NV; i++)
      if (m_act[i]) send_note(0, m_note[i], rc);
    check("all_off", ifc.voice_active, 0);
    wait_mix();
    ifc.ctrl = WAVE_SQR;
    for (int k = 70; k < 70 + NV; k++) begin
      inc_tab[k] = '0;
      send_note(1, k, rc);
    end
    wait_mix();
    check("square_full_scale", last_mix, NV * (HALF - 1));

    // Reset in the middle of a sweep
    do step(); while (cyc % SD != 0);
    repeat (5) step();
    reset = 1'b0;
    #1;
    check("midrst_mix_valid", ifc.mix_valid, 0);
    check("midrst_mix_out", ifc.mix_out, 0);
    check("midrst_active", ifc.voice_active, 0);
    check("midrst_lut_note", ifc.lut_note, 0);
    check("midrst_note_ready", ifc.note_ready, 0);
    seen = 0;
    repeat (NV + 4) begin
      @(posedge clk); #1;
      seen |= ifc.mix_valid;
    end
    check("midrst_no_pulse", seen, 0);
    model_clear();
    reset = 1'b1;
    cyc = 0; wraps = 0; pulses = 0; last_wrap = 0;
    wait_mix();
    check("post_rst_latency", mix_lat, NV + 1);
    check("post_rst_mix", last_mix, 0);
    check("post_rst_active", ifc.voice_active, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
